// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle control FSM for an RV32I datapath. Steps each
//               instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB, drives the
//               datapath selects and every write enable, handshakes with the
//               instruction and data memories, and parks in HALT with a
//               sticky bus_err when a memory never acknowledges.
// Ports       : clk, rst_n           - clock (rising edge), async active-low reset
//               instr                - IR contents, valid from DECODE on
//               iack, dack           - memory acknowledge pulses
//               br_taken             - branch comparator result (EXEC)
//               ireq, ir_we          - instruction fetch request / IR load
//               dreq, dwe            - data request / write qualifier
//               alub_sel, alu_op     - ALU operand-B select and operation
//               rf_we, wb_sel        - register write enable / source select
//               pc_we, pc_sel        - PC load strobe / source select
//               illegal, bus_err     - unsupported opcode pulse / sticky timeout
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int WAIT_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        iack,
    input  logic        dack,
    input  logic        br_taken,
    output logic        ireq,
    output logic        ir_we,
    output logic        dreq,
    output logic        dwe,
    output logic        alub_sel,
    output logic [3:0]  alu_op,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        illegal,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_R      = 3'd0,
        C_IALU   = 3'd1,
        C_LOAD   = 3'd2,
        C_STORE  = 3'd3,
        C_BRANCH = 3'd4,
        C_JAL    = 3'd5,
        C_JALR   = 3'd6,
        C_LUI    = 3'd7
    } cls_t;

    // Last count value at which a missing ack still leaves room; one more
    // silent cycle reaches 2**WAIT_W-1 and trips the timeout.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((2 ** WAIT_W) - 2);

    state_t            state_q, state_d;
    cls_t              cls_q, cls_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              bus_err_q, bus_err_d;

    cls_t              dec_cls;
    logic              dec_ok;
    logic              exe_alub;
    logic [3:0]        exe_op;
    logic              unused_instr;

    // Only opcode, funct3 and funct7[5] steer the controller.
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cls_q     <= C_R;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Opcode classifier
    always_comb begin
        dec_cls = C_R;
        dec_ok  = 1'b1;
        case (instr[6:0])
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_IALU;
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b1100011: dec_cls = C_BRANCH;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            7'b0110111: dec_cls = C_LUI;
            default:    dec_ok  = 1'b0;
        endcase
    end

    // ALU controls for the latched class; shared by EXEC and MEM so the
    // address computation stays stable while the data access is pending.
    always_comb begin
        exe_alub = !((cls_q == C_R) || (cls_q == C_BRANCH));
        case (cls_q)
            C_R:      exe_op = {instr[30], instr[14:12]};
            C_IALU:   exe_op = {instr[30] & (instr[14:12] == 3'b101), instr[14:12]};
            C_BRANCH: exe_op = 4'b1000;
            default:  exe_op = 4'b0000;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        wait_d    = wait_q;
        bus_err_d = bus_err_q;
        ireq      = 1'b0;
        ir_we     = 1'b0;
        dreq      = 1'b0;
        dwe       = 1'b0;
        alub_sel  = 1'b0;
        alu_op    = 4'b0000;
        rf_we     = 1'b0;
        wb_sel    = 2'b00;
        pc_we     = 1'b0;
        pc_sel    = 2'b00;
        illegal   = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                wait_d  = '0;
            end
            S_FETCH: begin
                ireq = 1'b1;
                if (iack) begin
                    ir_we   = 1'b1;
                    wait_d  = '0;
                    state_d = S_DECODE;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        bus_err_d = 1'b1;
                        state_d   = S_HALT;
                    end
                end
            end
            S_DECODE: begin
                if (dec_ok) begin
                    cls_d   = dec_cls;
                    state_d = S_EXEC;
                end else begin
                    // Skip the bad word: advance PC by 4 and refetch.
                    illegal = 1'b1;
                    pc_we   = 1'b1;
                    pc_sel  = 2'b00;
                    wait_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alub_sel = exe_alub;
                alu_op   = exe_op;
                case (cls_q)
                    C_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = br_taken ? 2'b01 : 2'b00;
                        wait_d  = '0;
                        state_d = S_FETCH;
                    end
                    C_LOAD, C_STORE: begin
                        wait_d  = '0;
                        state_d = S_MEM;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dreq     = 1'b1;
                dwe      = (cls_q == C_STORE);
                alub_sel = exe_alub;
                alu_op   = exe_op;
                if (dack) begin
                    wait_d = '0;
                    if (cls_q == C_STORE) begin
                        pc_we   = 1'b1;
                        pc_sel  = 2'b00;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        bus_err_d = 1'b1;
                        state_d   = S_HALT;
                    end
                end
            end
            S_WB: begin
                rf_we = 1'b1;
                pc_we = 1'b1;
                case (cls_q)
                    C_LOAD:         wb_sel = 2'b01;
                    C_JAL, C_JALR:  wb_sel = 2'b10;
                    C_LUI:          wb_sel = 2'b11;
                    default:        wb_sel = 2'b00;
                endcase
                case (cls_q)
                    C_JAL:   pc_sel = 2'b01;
                    C_JALR:  pc_sel = 2'b10;
                    default: pc_sel = 2'b00;
                endcase
                wait_d  = '0;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus_err = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed self-checking bench for multicycle_ctrl. Inputs are
//               driven on the falling edge, outputs sampled 1 ns later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        iack;
    logic        dack;
    logic        br_taken;
    logic        ireq;
    logic        ir_we;
    logic        dreq;
    logic        dwe;
    logic        alub_sel;
    logic [3:0]  alu_op;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        illegal;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    logic [16:0] outs;
    assign outs = {ireq, ir_we, dreq, dwe, alub_sel, alu_op, rf_we,
                   wb_sel, pc_we, pc_sel, illegal, bus_err};

    multicycle_ctrl #(.WAIT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr),
        .iack     (iack),
        .dack     (dack),
        .br_taken (br_taken),
        .ireq     (ireq),
        .ir_we    (ir_we),
        .dreq     (dreq),
        .dwe      (dwe),
        .alub_sel (alub_sel),
        .alu_op   (alu_op),
        .rf_we    (rf_we),
        .wb_sel   (wb_sel),
        .pc_we    (pc_we),
        .pc_sel   (pc_sel),
        .illegal  (illegal),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge +1 with the FSM in FETCH; returns in DECODE.
    task automatic fetch(input logic [31:0] ins, input int dly);
        for (int i = 0; i < dly; i++) begin
            iack = 1'b0;
            #1;
            chk("fetch_wait_ireq", ireq, 1);
            chk("fetch_wait_irwe", ir_we, 0);
            @(negedge clk);
        end
        iack  = 1'b1;
        instr = ins;
        #1;
        chk("fetch_ack_ireq", ireq, 1);
        chk("fetch_ack_irwe", ir_we, 1);
        @(negedge clk);
        iack = 1'b0;
        #1;
        chk("decode_ireq_low", ireq, 0);
    endtask

    // Full FETCH/DECODE/EXEC/WB pass; returns in the next FETCH.
    task automatic run_wb(input logic [31:0] ins, input int dly, input logic e_alub,
                          input logic [3:0] e_op, input logic [1:0] e_wb,
                          input logic [1:0] e_pc);
        fetch(ins, dly);
        chk("decode_illegal", illegal, 0);
        chk("decode_pcwe", pc_we, 0);
        @(negedge clk); #1;
        chk("exec_alub", alub_sel, e_alub);
        chk("exec_aluop", alu_op, e_op);
        chk("exec_rfwe", rf_we, 0);
        @(negedge clk); #1;
        chk("wb_rfwe", rf_we, 1);
        chk("wb_pcwe", pc_we, 1);
        chk("wb_irwe", ir_we, 0);
        chk("wb_sel", wb_sel, e_wb);
        chk("wb_pcsel", pc_sel, e_pc);
        @(negedge clk); #1;
        chk("refetch_ireq", ireq, 1);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        instr    = 32'h0;
        iack     = 1'b0;
        dack     = 1'b0;
        br_taken = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outs", outs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_ireq", ireq, 0);
        @(negedge clk); #1;
        chk("first_ireq", ireq, 1);

        // addi x1,x0,5 with the ack two cycles after the request
        run_wb(32'h00500093, 2, 1'b1, 4'b0000, 2'b00, 2'b00);

        // sw with dack delayed 3 cycles
        fetch(32'h0020A023, 0);
        chk("sw_decode_pcwe", pc_we, 0);
        @(negedge clk); #1;
        chk("sw_exec_alub", alub_sel, 1);
        chk("sw_exec_dreq", dreq, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dack = (i == 3);
            #1;
            chk("sw_mem_dreq", dreq, 1);
            chk("sw_mem_dwe", dwe, 1);
            chk("sw_mem_rfwe", rf_we, 0);
            chk("sw_mem_pcwe", pc_we, (i == 3) ? 1 : 0);
            chk("sw_mem_alub", alub_sel, 1);
        end
        chk("sw_pcsel", pc_sel, 0);
        @(negedge clk);
        dack = 1'b0;
        #1;
        chk("sw_dreq_drop", dreq, 0);
        chk("sw_rfwe", rf_we, 0);
        chk("sw_refetch", ireq, 1);

        // beq taken, then not taken
        fetch(32'h00208463, 0);
        @(negedge clk);
        br_taken = 1'b1;
        #1;
        chk("beq_t_pcwe", pc_we, 1);
        chk("beq_t_pcsel", pc_sel, 2'b01);
        chk("beq_alub", alub_sel, 0);
        chk("beq_aluop", alu_op, 4'b1000);
        @(negedge clk);
        br_taken = 1'b0;
        #1;
        chk("beq_refetch", ireq, 1);
        fetch(32'h00208463, 0);
        @(negedge clk); #1;
        chk("beq_nt_pcwe", pc_we, 1);
        chk("beq_nt_pcsel", pc_sel, 2'b00);
        @(negedge clk); #1;
        chk("beq_nt_refetch", ireq, 1);

        // Remaining classes
        run_wb(32'h40115093, 0, 1'b1, 4'b1101, 2'b00, 2'b00); // srai
        run_wb(32'h40208033, 0, 1'b0, 4'b1000, 2'b00, 2'b00); // sub
        run_wb(32'h008000EF, 0, 1'b1, 4'b0000, 2'b10, 2'b01); // jal
        run_wb(32'h000080E7, 0, 1'b1, 4'b0000, 2'b10, 2'b10); // jalr
        run_wb(32'h000010B7, 0, 1'b1, 4'b0000, 2'b11, 2'b00); // lui

        // Unsupported opcode
        fetch(32'hFFFFFFFF, 0);
        chk("ill_pulse", illegal, 1);
        chk("ill_pcwe", pc_we, 1);
        chk("ill_pcsel", pc_sel, 0);
        chk("ill_rfwe", rf_we, 0);
        @(negedge clk); #1;
        chk("ill_drop", illegal, 0);
        chk("ill_refetch", ireq, 1);

        // Ack on the cycle the counter would saturate wins
        run_wb(32'h00500093, 14, 1'b1, 4'b0000, 2'b00, 2'b00);
        chk("sat_ack_no_err", bus_err, 0);

        // Instruction-side timeout
        iack = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !bus_err; i++) begin
            if (ireq) n++;
            @(negedge clk); #1;
        end
        chk("to_ireq_cycles", n, 15);
        chk("to_bus_err", bus_err, 1);
        chk("to_ireq_low", ireq, 0);
        iack = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("halt_strobes", outs[16:1], 0);
            chk("halt_bus_err", bus_err, 1);
        end
        iack = 1'b0;

        // Reset clears bus_err; ireq one cycle after release
        rst_n = 1'b0;
        #1;
        chk("rst_bus_err", bus_err, 0);
        chk("rst_outs", outs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ireq0", ireq, 0);
        @(negedge clk); #1;
        chk("rel_ireq1", ireq, 1);

        // Reset pulsed mid-MEM of a load
        fetch(32'h0000A083, 0);
        @(negedge clk); #1;
        chk("lw_exec_alub", alub_sel, 1);
        @(negedge clk); #1;
        chk("lw_mem_dreq", dreq, 1);
        chk("lw_mem_dwe", dwe, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("lw_async_dreq", dreq, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk); #1;
            if (rf_we) n++;
        end
        chk("lw_no_rfwe", n, 0);
        chk("lw_after_ireq", ireq, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
